// File: rtl/rps_vga_pkg.sv
// Shared types and constants for the rock-paper-scissors VGA display path.
package rps_vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

    localparam int IMG_ROCK    = 0;
    localparam int IMG_SCISSOR = 1;
    localparam int IMG_PAPER   = 2;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_WHITE = 3'b111;

endpackage

// File: rtl/rps_raster_counter.sv
// Column/row raster scan counter: column fastest, wraps to (0,0) after the last pixel.
module rps_raster_counter
    import rps_vga_pkg::*;
#(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int CW = 8,
    parameter int RW = 7
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic          col_end;
    logic          row_end;

    assign col_end = (col_reg == CW'(W - 1));
    assign row_end = (row_reg == RW'(H - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clear) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (en) begin
            if (col_end) begin
                col_reg <= '0;
                row_reg <= row_end ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign col  = col_reg;
    assign row  = row_reg;
    assign last = col_end && row_end;

endmodule

// File: rtl/rps_sprite_blitter.sv
// Two-colour clipped image blitter into the vga_adapter plot port, start/busy/done handshake.
module rps_sprite_blitter
    import rps_vga_pkg::*;
#(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int SPR_W       = 160,
    parameter int SPR_H       = 120,
    parameter int NUM_IMG     = 3,
    parameter int COLOUR_BITS = 3,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int AW          = 15,
    localparam int SELW       = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SELW-1:0]        sel,
    input  logic [XW-1:0]          x0,
    input  logic [YW-1:0]          y0,
    input  logic [COLOUR_BITS-1:0] fg,
    input  logic [COLOUR_BITS-1:0] bg,
    input  logic                   transparent,
    output logic                   busy,
    output logic                   done,
    output logic [SELW-1:0]        rom_sel,
    output logic [AW-1:0]          rom_addr,
    input  logic                   rom_q,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [SELW:0] NUM_IMG_L = (SELW + 1)'(NUM_IMG);

    blit_state_t state_reg, state_next;
    logic        drain_reg;

    logic [SELW-1:0]        sel_reg;
    logic [XW-1:0]          x0_reg;
    logic [YW-1:0]          y0_reg;
    logic [COLOUR_BITS-1:0] fg_reg, bg_reg;
    logic                   transparent_reg;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          scan_last;
    logic          scan_clear;
    logic          scan_en;

    // Issue stage: address register plus the matching screen coordinate.
    logic [AW-1:0] rom_addr_reg;
    logic [XW:0]   a_x_reg;
    logic [YW:0]   a_y_reg;
    logic          a_valid_reg;
    logic          a_last_reg;

    // Stage 1: coordinates travel alongside the ROM lookup.
    logic [XW:0]   s1_x_reg;
    logic [YW:0]   s1_y_reg;
    logic          s1_valid_reg;

    logic [XW-1:0]          x_reg;
    logic [YW-1:0]          y_reg;
    logic [COLOUR_BITS-1:0] colour_reg;
    logic                   plot_reg;

    assign scan_clear = (state_reg == IDLE);
    assign scan_en    = (state_reg == RUN) && !a_last_reg;

    rps_raster_counter #(
        .W  (SPR_W),
        .H  (SPR_H),
        .CW (CW),
        .RW (RW)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clear    (scan_clear),
        .en       (scan_en),
        .col      (col),
        .row      (row),
        .last     (scan_last)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            drain_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            drain_reg <= (state_reg == DRAIN) ? ~drain_reg : 1'b0;
        end
    end

    // RUN holds until the register carrying the last address has been out for a cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (a_last_reg) state_next = DRAIN;
            DRAIN:   if (drain_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sel_reg         <= '0;
            x0_reg          <= '0;
            y0_reg          <= '0;
            fg_reg          <= '0;
            bg_reg          <= '0;
            transparent_reg <= 1'b0;
            rom_addr_reg    <= '0;
            a_x_reg         <= '0;
            a_y_reg         <= '0;
            a_valid_reg     <= 1'b0;
            a_last_reg      <= 1'b0;
            s1_x_reg        <= '0;
            s1_y_reg        <= '0;
            s1_valid_reg    <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            colour_reg      <= '0;
            plot_reg        <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                sel_reg         <= ({1'b0, sel} >= NUM_IMG_L) ? SELW'(NUM_IMG - 1) : sel;
                x0_reg          <= x0;
                y0_reg          <= y0;
                fg_reg          <= fg;
                bg_reg          <= bg;
                transparent_reg <= transparent;
            end

            a_valid_reg <= scan_en;
            a_last_reg  <= scan_en && scan_last;
            if (scan_en) begin
                rom_addr_reg <= AW'(row) * AW'(SPR_W) + AW'(col);
                a_x_reg      <= {1'b0, x0_reg} + (XW + 1)'(col);
                a_y_reg      <= {1'b0, y0_reg} + (YW + 1)'(row);
            end

            s1_valid_reg <= a_valid_reg;
            s1_x_reg     <= a_x_reg;
            s1_y_reg     <= a_y_reg;

            if (s1_valid_reg) begin
                x_reg      <= s1_x_reg[XW-1:0];
                y_reg      <= s1_y_reg[YW-1:0];
                colour_reg <= rom_q ? fg_reg : bg_reg;
            end
            plot_reg <= s1_valid_reg
                        && (s1_x_reg < (XW + 1)'(SCREEN_W))
                        && (s1_y_reg < (YW + 1)'(SCREEN_H))
                        && (rom_q || !transparent_reg);
        end
    end

    assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);
    assign rom_sel  = sel_reg;
    assign rom_addr = rom_addr_reg;
    assign x        = x_reg;
    assign y        = y_reg;
    assign colour   = colour_reg;
    assign plot     = plot_reg;

endmodule

// File: tb/tb_rps_sprite_blitter.sv
// Directed bench: 4x2 image blits from a vector table, reset mid-blit, and a full-screen blit.
module tb_rps_sprite_blitter;
    import rps_vga_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Small 4x2 instance
    logic       start, transparent, busy, done, plot, rom_q;
    logic [1:0] sel, rom_sel;
    logic [7:0] x0, x;
    logic [6:0] y0, y;
    logic [2:0] fg, bg, colour, rom_addr;

    rps_sprite_blitter #(
        .SCREEN_W(160), .SCREEN_H(120), .SPR_W(4), .SPR_H(2),
        .NUM_IMG(3), .COLOUR_BITS(3), .XW(8), .YW(7), .AW(3)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .sel(sel),
        .x0(x0), .y0(y0), .fg(fg), .bg(bg), .transparent(transparent),
        .busy(busy), .done(done), .rom_sel(rom_sel), .rom_addr(rom_addr),
        .rom_q(rom_q), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    logic [7:0] img_mem [3];
    initial begin
        img_mem[0] = 8'h00;
        img_mem[1] = 8'hA5;
        img_mem[2] = 8'hF0;
    end
    always @(posedge CLOCK_50) rom_q <= img_mem[rom_sel][rom_addr];

    // Full-screen default instance
    logic        start_f, transparent_f, busy_f, done_f, plot_f, rom_q_f;
    logic [1:0]  sel_f, rom_sel_f;
    logic [7:0]  x0_f, x_f;
    logic [6:0]  y0_f, y_f;
    logic [2:0]  fg_f, bg_f, colour_f;
    logic [14:0] rom_addr_f;

    rps_sprite_blitter dut_full (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_f), .sel(sel_f),
        .x0(x0_f), .y0(y0_f), .fg(fg_f), .bg(bg_f), .transparent(transparent_f),
        .busy(busy_f), .done(done_f), .rom_sel(rom_sel_f), .rom_addr(rom_addr_f),
        .rom_q(rom_q_f), .x(x_f), .y(y_f), .colour(colour_f), .plot(plot_f)
    );

    always @(posedge CLOCK_50) rom_q_f <= rom_addr_f[0] ^ rom_addr_f[5];

    typedef struct {
        logic [1:0]        sel;
        logic [7:0]        x0;
        logic [6:0]        y0;
        logic [2:0]        fg;
        logic [2:0]        bg;
        logic              tr;
        logic              mid;
        logic [1:0]        esel;
        logic [0:7]        ep;
        logic [0:7][7:0]   ex;
        logic [0:7][6:0]   ey;
        logic [0:7][2:0]   ec;
    } vec_t;

    vec_t tv [5];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        @(negedge CLOCK_50);
        sel = tv[i].sel; x0 = tv[i].x0; y0 = tv[i].y0;
        fg = tv[i].fg; bg = tv[i].bg; transparent = tv[i].tr;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        chk("busy_after_accept", busy, 1);
        for (int c = 1; c <= 13; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (c == 1) chk("rom_sel", rom_sel, tv[i].esel);
            if (c == 5 && tv[i].mid) begin
                start = 1'b1; sel = 2'd0; x0 = 8'd99; y0 = 7'd5;
                fg = 3'd0; bg = 3'd0; transparent = 1'b1;
            end
            if (c == 6) start = 1'b0;
            if (c >= 3 && c <= 10) begin
                chk($sformatf("plot_v%0d_p%0d", i, c - 3), plot, tv[i].ep[c-3]);
                if (tv[i].ep[c-3]) begin
                    chk($sformatf("x_v%0d_p%0d", i, c - 3), x, tv[i].ex[c-3]);
                    chk($sformatf("y_v%0d_p%0d", i, c - 3), y, tv[i].ey[c-3]);
                    chk($sformatf("colour_v%0d_p%0d", i, c - 3), colour, tv[i].ec[c-3]);
                end
            end
            if (c == 10) begin
                chk("done_before_end", done, 0);
                chk("busy_before_end", busy, 1);
            end
            if (c == 11) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
            end
            if (c >= 12) begin
                chk("done_after_pulse", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_plot", plot, 0);
            end
        end
        $display("vec %0d sel %0d x0 %0d y0 %0d tr %0d mid %0d complete",
                 i, tv[i].sel, tv[i].x0, tv[i].y0, tv[i].tr, tv[i].mid);
    endtask

    initial begin
        int idx, lat, bad;
        logic [14:0] maxa, ia;
        logic [2:0]  ecol;

        tv[0].sel = 2'd1; tv[0].x0 = 8'd10; tv[0].y0 = 7'd20; tv[0].fg = 3'd7; tv[0].bg = 3'd2;
        tv[0].tr = 1'b0; tv[0].mid = 1'b0; tv[0].esel = 2'd1; tv[0].ep = 8'b1111_1111;
        tv[0].ex = {8'd10, 8'd11, 8'd12, 8'd13, 8'd10, 8'd11, 8'd12, 8'd13};
        tv[0].ey = {7'd20, 7'd20, 7'd20, 7'd20, 7'd21, 7'd21, 7'd21, 7'd21};
        tv[0].ec = {3'd7, 3'd2, 3'd7, 3'd2, 3'd2, 3'd7, 3'd2, 3'd7};

        tv[1] = tv[0];
        tv[1].tr = 1'b1; tv[1].ep = 8'b1010_0101;

        tv[2] = tv[0];
        tv[2].x0 = 8'd158; tv[2].y0 = 7'd119; tv[2].ep = 8'b1100_0000;
        tv[2].ex = {8'd158, 8'd159, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tv[2].ey = {7'd119, 7'd119, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        tv[2].ec = {3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

        tv[3] = tv[0];
        tv[3].mid = 1'b1;

        tv[4].sel = 2'd3; tv[4].x0 = 8'd0; tv[4].y0 = 7'd0; tv[4].fg = 3'd5; tv[4].bg = 3'd1;
        tv[4].tr = 1'b0; tv[4].mid = 1'b0; tv[4].esel = 2'd2; tv[4].ep = 8'b1111_1111;
        tv[4].ex = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
        tv[4].ey = {7'd0, 7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1};
        tv[4].ec = {3'd1, 3'd1, 3'd1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5};

        start = 1'b0; sel = '0; x0 = '0; y0 = '0; fg = '0; bg = '0; transparent = 1'b0;
        start_f = 1'b0; sel_f = 2'd0; x0_f = '0; y0_f = '0;
        fg_f = COL_WHITE; bg_f = COL_BLACK; transparent_f = 1'b0;

        #2 reset_n = 1'b0;
        #20;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_sel", rom_sel, 0);
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        $display("reset released");

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset in the middle of a blit, just after the third plot
        @(negedge CLOCK_50);
        sel = 2'd1; x0 = 8'd10; y0 = 7'd20; fg = 3'd7; bg = 3'd2; transparent = 1'b0;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLOCK_50);
            #1;
        end
        chk("pre_rst_plot", plot, 1);
        chk("pre_rst_busy", busy, 1);
        #4 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_plot", plot, 0);
        chk("async_rst_done", done, 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1 chk("post_rst_idle", busy, 0);
        $display("reset mid-blit applied and released");
        run_vec(0);

        // Full-screen blit with default parameters
        @(negedge CLOCK_50);
        start_f = 1'b1;
        @(posedge CLOCK_50);
        #1 start_f = 1'b0;
        idx = 0; lat = 0; bad = 0; maxa = '0;
        for (int c = 1; c <= 19300 && lat == 0; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (rom_addr_f > maxa) maxa = rom_addr_f;
            if (plot_f) begin
                ia = 15'(idx);
                ecol = (ia[0] ^ ia[5]) ? COL_WHITE : COL_BLACK;
                if (x_f != 8'(idx % 160) || y_f != 7'(idx / 160) || colour_f != ecol) bad++;
                idx++;
            end
            if (done_f) lat = c;
        end
        chk("full_latency", lat, 19203);
        chk("full_plot_count", idx, 19200);
        chk("full_raster_order_bad", bad, 0);
        chk("full_max_addr", maxa, 19199);
        $display("full-screen blit plots %0d latency %0d", idx, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
